// File: rtl/am_pm_hour_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hour_track_pkg
//  Purpose  : Shared types and constants for the AM/PM hour tracker.
//             Holds the FSM state type, the counter modulus, the 7-segment
//             constants and the count -> 12-hour BCD mapping helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hour_track_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int MOD = 12;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry i is the pattern for decimal digit i.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_hour_t;

  // Counter value 0 is shown as 12 o'clock; 1..11 are shown as themselves.
  function automatic bcd_hour_t count_to_hour(input logic [3:0] count);
    bcd_hour_t h;
    if (count == 4'd0) begin
      h.tens = 4'd1;
      h.ones = 4'd2;
    end else if (count >= 4'd10) begin
      h.tens = 4'd1;
      h.ones = count - 4'd10;
    end else begin
      h.tens = 4'd0;
      h.ones = count;
    end
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/am_pm_hour_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : am_pm_hour_tracker_if
//  Purpose  : Bundles the counter-facing inputs and display/status outputs
//             of the AM/PM hour tracker.
//  Ports    : count_in, clear_err        (driven by master)
//             hour_tens, hour_ones, seg_tens, seg_ones, pm, wrap_pulse,
//             day_count, step_err        (driven by slave = tracker)
//  Revision : 1.0  initial release
// ============================================================================
interface am_pm_hour_tracker_if #(
  parameter int DAY_W = 8
);
  logic [3:0]       count_in;
  logic             clear_err;
  logic [3:0]       hour_tens;
  logic [3:0]       hour_ones;
  logic [6:0]       seg_tens;
  logic [6:0]       seg_ones;
  logic             pm;
  logic             wrap_pulse;
  logic [DAY_W-1:0] day_count;
  logic             step_err;

  modport master (
    output count_in, clear_err,
    input  hour_tens, hour_ones, seg_tens, seg_ones,
    input  pm, wrap_pulse, day_count, step_err
  );

  modport slave (
    input  count_in, clear_err,
    output hour_tens, hour_ones, seg_tens, seg_ones,
    output pm, wrap_pulse, day_count, step_err
  );
endinterface
`default_nettype wire

// File: rtl/am_pm_hour_tracker_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_7seg
//  Purpose  : Combinational BCD digit to 7-segment pattern (active-high),
//             with dash and blank overrides. Dash has priority over blank;
//             non-decimal codes render blank.
//  Ports    : bcd   in  4  digit 0..9
//             blank in  1  force all segments off
//             dash  in  1  force segment g only
//             seg   out 7  {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_7seg
  import hour_track_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank && (bcd < 4'd10)) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule
`default_nettype wire

// File: rtl/am_pm_hour_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : am_pm_hour_tracker
//  Purpose  : Follows a modulo-12 counter stream, shows the hour in 12-hour
//             notation on two 7-segment digits, tracks AM/PM and completed
//             days, and flags illegal counter values or steps.
//  Ports    : clock   in   1  posedge clock
//             resetn  in   1  asynchronous active-low reset
//             bus     slave modport of am_pm_hour_tracker_if
//               count_in/clear_err in; hour_tens/hour_ones, seg_tens/seg_ones,
//               pm, wrap_pulse, day_count, step_err out (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module am_pm_hour_tracker
  import hour_track_pkg::*;
#(
  parameter int DAY_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LEAD     = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  am_pm_hour_tracker_if.slave bus
);

  localparam logic [6:0] SEG_POL  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] LAST_CNT = 4'(MOD - 1);

  state_t           state;
  logic [3:0]       last_q;
  logic [3:0]       hour_tens;
  logic [3:0]       hour_ones;
  logic [6:0]       seg_tens;
  logic [6:0]       seg_ones;
  logic             pm;
  logic             wrap_pulse;
  logic [DAY_W-1:0] day_count;
  logic             step_err;

  logic [3:0] next_q;
  logic       count_legal;
  logic       step_ok;
  logic       is_wrap;
  logic       load;
  logic       to_err;
  bcd_hour_t  new_hour;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;
  logic       blank_tens;
  logic [6:0] seg_tens_raw;
  logic [6:0] seg_ones_raw;

  assign count_legal = (bus.count_in <= LAST_CNT);
  assign next_q      = (last_q == LAST_CNT) ? 4'd0 : last_q + 4'd1;
  assign step_ok     = count_legal &&
                       ((bus.count_in == last_q) || (bus.count_in == next_q));
  assign is_wrap     = (last_q == LAST_CNT) && (bus.count_in == 4'd0);
  assign new_hour    = count_to_hour(bus.count_in);

  // Lookahead of the FSM decision so the segment registers can be loaded
  // with the pattern that matches the BCD/state being registered this edge.
  // clear_err always wins over an illegal sample in the same cycle.
  assign load   = !bus.clear_err &&
                  (((state == SYNC) && count_legal) || ((state == RUN) && step_ok));
  assign to_err = !bus.clear_err &&
                  (((state == SYNC) && !count_legal) ||
                   ((state == RUN)  && !step_ok) ||
                   (state == ERR));

  assign dig_tens   = load ? new_hour.tens : hour_tens;
  assign dig_ones   = load ? new_hour.ones : hour_ones;
  assign blank_tens = BLANK_LEAD && (dig_tens == 4'd0);

  bcd_to_7seg u_seg_tens (
    .bcd   (dig_tens),
    .blank (blank_tens),
    .dash  (to_err),
    .seg   (seg_tens_raw)
  );

  bcd_to_7seg u_seg_ones (
    .bcd   (dig_ones),
    .blank (1'b0),
    .dash  (to_err),
    .seg   (seg_ones_raw)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= SYNC;
      last_q     <= 4'd0;
      hour_tens  <= 4'd1;
      hour_ones  <= 4'd2;
      seg_tens   <= SEG_DIGITS[1] ^ SEG_POL;
      seg_ones   <= SEG_DIGITS[2] ^ SEG_POL;
      pm         <= 1'b0;
      wrap_pulse <= 1'b0;
      day_count  <= '0;
      step_err   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      seg_tens   <= seg_tens_raw ^ SEG_POL;
      seg_ones   <= seg_ones_raw ^ SEG_POL;
      if (bus.clear_err) begin
        step_err <= 1'b0;
        state    <= SYNC;
      end else begin
        case (state)
          SYNC: begin
            if (count_legal) begin
              last_q    <= bus.count_in;
              hour_tens <= new_hour.tens;
              hour_ones <= new_hour.ones;
              state     <= RUN;
            end else begin
              step_err <= 1'b1;
              state    <= ERR;
            end
          end
          RUN: begin
            if (step_ok) begin
              last_q    <= bus.count_in;
              hour_tens <= new_hour.tens;
              hour_ones <= new_hour.ones;
              if (is_wrap) begin
                wrap_pulse <= 1'b1;
                pm         <= !pm;
                // A PM -> AM change completes a day.
                if (pm) begin
                  day_count <= day_count + DAY_W'(1);
                end
              end
            end else begin
              step_err <= 1'b1;
              state    <= ERR;
            end
          end
          ERR: begin
            state <= ERR;
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end
    end
  end

  assign bus.hour_tens  = hour_tens;
  assign bus.hour_ones  = hour_ones;
  assign bus.seg_tens   = seg_tens;
  assign bus.seg_ones   = seg_ones;
  assign bus.pm         = pm;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.day_count  = day_count;
  assign bus.step_err   = step_err;

endmodule
`default_nettype wire

// File: tb/tb_am_pm_hour_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_am_pm_hour_tracker
//  Purpose  : Self-checking bench for am_pm_hour_tracker. A stimulus process
//             drives the counter stream and pushes expected outputs, computed
//             by a behavioural clock model, into a scoreboard queue; a
//             monitor pops and compares one entry per clock.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_am_pm_hour_tracker;

  localparam int TB_DAY_W = 3;
  localparam int DAYS_MOD = 1 << TB_DAY_W;

  typedef struct {
    int tens;
    int ones;
    int seg_t;
    int seg_o;
    int pm;
    int wrap;
    int day;
    int err;
  } exp_t;

  logic clock;
  logic resetn;

  am_pm_hour_tracker_if #(.DAY_W(TB_DAY_W)) bus ();

  am_pm_hour_tracker #(
    .DAY_W          (TB_DAY_W),
    .SEG_ACTIVE_LOW (1'b0),
    .BLANK_LEAD     (1'b1)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Digit glyphs for a seven-segment display, indexed by decimal digit.
  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  // Behavioural model: an hour hand, an AM/PM flag, a day tally and an
  // error latch. "synced" means a reference count has been captured.
  bit m_synced, m_err, m_pm, m_wrap;
  int m_last, m_hour, m_days;
  int cur;

  function automatic void m_reset();
    m_synced = 0; m_err = 0; m_pm = 0; m_wrap = 0;
    m_last = 0; m_hour = 12; m_days = 0;
  endfunction

  function automatic void m_edge(int c, bit clr);
    m_wrap = 0;
    if (clr) begin
      m_err = 0;
      m_synced = 0;
    end else if (m_err) begin
      // count ignored while in error
    end else if (!m_synced) begin
      if (c < 12) begin
        m_last = c; m_hour = (c == 0) ? 12 : c; m_synced = 1;
      end else begin
        m_err = 1;
      end
    end else begin
      if (c < 12 && (c == m_last || c == (m_last + 1) % 12)) begin
        if (m_last == 11 && c == 0) begin
          m_wrap = 1;
          if (m_pm) m_days = (m_days + 1) % DAYS_MOD;
          m_pm = !m_pm;
        end
        m_last = c; m_hour = (c == 0) ? 12 : c;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    e.tens = m_hour / 10;
    e.ones = m_hour % 10;
    if (m_err) begin
      e.seg_t = 'h40; e.seg_o = 'h40;
    end else begin
      e.seg_t = (e.tens == 0) ? 'h00 : seg_tab[e.tens];
      e.seg_o = seg_tab[e.ones];
    end
    e.pm = m_pm; e.wrap = m_wrap; e.day = m_days; e.err = m_err;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " hour_tens"},  int'(bus.hour_tens),  e.tens);
    chk({tag, " hour_ones"},  int'(bus.hour_ones),  e.ones);
    chk({tag, " seg_tens"},   int'(bus.seg_tens),   e.seg_t);
    chk({tag, " seg_ones"},   int'(bus.seg_ones),   e.seg_o);
    chk({tag, " pm"},         int'(bus.pm),         e.pm);
    chk({tag, " wrap_pulse"}, int'(bus.wrap_pulse), e.wrap);
    chk({tag, " day_count"},  int'(bus.day_count),  e.day);
    chk({tag, " step_err"},   int'(bus.step_err),   e.err);
  endtask

  // Monitor: outputs are valid every cycle, one scoreboard entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all("mon", e);
      end
    end
  end

  task automatic step(input int c, input bit clr);
    @(negedge clock);
    resetn        = 1'b1;
    bus.count_in  = 4'(c);
    bus.clear_err = clr;
    m_edge(c, clr);
    sb.push_back(m_exp());
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      resetn        = 1'b0;
      bus.clear_err = 1'b0;
      m_reset();
      if (i == 0) begin
        #1;
        chk_all("async_reset", m_exp());
      end
      sb.push_back(m_exp());
    end
    cur = 0;
  endtask

  // Mostly-advancing counter with random holds.
  task automatic run_legal(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) cur = (cur + 1) % 12;
      step(cur, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    bus.count_in  = 4'd0;
    bus.clear_err = 1'b0;
    m_reset();
    cur = 0;
    do_reset(3);

    // Clean 0..11 sequence, then random run long enough for several
    // day_count wraps with a 3-bit counter.
    for (int i = 0; i < 12; i++) step(i, 1'b0);
    cur = 11;
    run_legal(520);

    // Skipped step 5 -> 7, garbage while in error, clear with an illegal
    // value on the same cycle, then resync on 8.
    step(0, 1'b1);
    step(5, 1'b0);
    step(7, 1'b0);
    step(11, 1'b0);
    step(0, 1'b0);
    step(3, 1'b0);
    step(14, 1'b1);
    step(8, 1'b0);
    cur = 8;
    run_legal(30);

    // Illegal value straight after reset.
    do_reset(2);
    step(13, 1'b0);
    step(12, 1'b0);
    step(14, 1'b1);
    step(8, 1'b0);
    step(9, 1'b0);

    // Hold on 3 for five cycles.
    step(0, 1'b1);
    for (int i = 0; i < 5; i++) step(3, 1'b0);
    cur = 3;

    // Run until afternoon of a later day, then reset asynchronously.
    for (int i = 0; i < 2000 && !(m_pm && m_days != 0); i++) run_legal(1);
    chk("reached_pm_day", int'(m_pm && m_days != 0), 1);
    do_reset(2);

    // Random mix of legal steps, illegal values and clears.
    cur = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        step($urandom_range(0, 15), 1'b0);
      end else if (r < 8) begin
        step($urandom_range(0, 15), 1'b1);
      end else begin
        run_legal(1);
      end
    end

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
